// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, overflow FSM states and TAC clock-select decode for timer_regs
package timer_pkg;
  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;
  typedef enum logic [1:0] {TimerIdle, TimerOvf, TimerReload} timer_state_e;
  function automatic logic [3:0] tac_bit(input logic [1:0] clk_sel);
    return clk_sel == 2'd0 ? 4'd9 : clk_sel == 2'd1 ? 4'd3 : clk_sel == 2'd2 ? 4'd5 : 4'd7;
  endfunction
endpackage

// File: rtl/timer_regs.sv
// timer_regs: DIV/TIMA/TMA/TAC timer at BASE_ADDR..+3 with delayed TMA reload and irq pulse.
// Optional macro TIMER_APU_TICK_EN adds apu_div_tick, a pulse on each falling edge of counter bit 12.
module timer_regs
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic        bus_commit,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_hit,
`ifdef TIMER_APU_TICK_EN
  output logic        apu_div_tick,
`endif
  output logic        irq_timer
);
  logic [15:0] sys_counter, off;
  logic [7:0] tima, tma;
  logic [2:0] tac;
  logic [1:0] ovf_cnt;
  logic edge_prev, sel, tick, wr, wr_div, wr_tima, wr_tma, wr_tac;
  timer_state_e state;
  always_comb begin
    off = mem_addr - BASE_ADDR;
    mem_hit = mem_enable && off[15:2] == 14'd0;
    wr = mem_hit && mem_write && bus_commit;
    wr_div = wr && off[1:0] == REG_DIV;
    wr_tima = wr && off[1:0] == REG_TIMA;
    wr_tma = wr && off[1:0] == REG_TMA;
    wr_tac = wr && off[1:0] == REG_TAC;
    sel = sys_counter[tac_bit(tac[1:0])] & tac[2];
    tick = edge_prev & ~sel;
    mem_data_out = !mem_hit ? 8'hFF :
                   off[1:0] == REG_DIV ? sys_counter[15:8] :
                   off[1:0] == REG_TIMA ? tima :
                   off[1:0] == REG_TMA ? tma : {5'b11111, tac};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sys_counter <= '0;
      tima <= '0;
      tma <= '0;
      tac <= '0;
      edge_prev <= 1'b0;
      ovf_cnt <= '0;
      state <= TimerIdle;
      irq_timer <= 1'b0;
    end else begin
      sys_counter <= wr_div ? 16'd0 : sys_counter + 16'd1;
      edge_prev <= sel;
      irq_timer <= 1'b0;
      ovf_cnt <= ovf_cnt + 2'd1;
      if (wr_tma) tma <= mem_data_in;
      if (wr_tac) tac <= mem_data_in[2:0];
      if (state == TimerIdle) begin
        if (wr_tima) tima <= mem_data_in;
        else if (tick) begin
          tima <= tima + 8'd1;
          if (tima == 8'hFF) begin
            state <= TimerOvf;
            ovf_cnt <= 2'd0;
          end
        end
      end else if (state == TimerOvf) begin
        // a CPU write during the overflow window cancels the pending reload and irq
        if (wr_tima) begin
          tima <= mem_data_in;
          state <= TimerIdle;
        end else if (ovf_cnt == 2'd3) begin
          tima <= tma;
          irq_timer <= 1'b1;
          state <= TimerReload;
          ovf_cnt <= 2'd0;
        end else if (tick) tima <= tima + 8'd1;
      end else begin
        if (wr_tma) tima <= mem_data_in;
        else if (tick) tima <= tima + 8'd1;
        if (ovf_cnt == 2'd3) state <= TimerIdle;
      end
    end
`ifdef TIMER_APU_TICK_EN
  logic div12_prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div12_prev <= 1'b0;
    else div12_prev <= sys_counter[12];
  assign apu_div_tick = div12_prev & ~sys_counter[12];
`endif
endmodule

// File: tb/tb_timer_regs.sv
// tb_timer_regs: table-driven register vectors plus directed tick, overflow, reload and reset sequences.
module tb_timer_regs;
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] mem_addr;
  logic mem_enable, mem_write, bus_commit;
  logic [7:0] mem_data_in, mem_data_out;
  logic mem_hit, irq_timer, seen;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic wr;
    logic cm;
    logic en;
    logic [15:0] addr;
    logic [7:0] wd;
    logic hit;
    logic [7:0] rd;
  } vec_t;
  vec_t v[10];

  always #5 clk = ~clk;

`ifdef TIMER_APU_TICK_EN
  logic apu_div_tick;
  int apu_cnt = 0;
  always @(negedge clk) if (apu_div_tick) apu_cnt <= apu_cnt + 1;
`endif

  timer_regs dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_addr(mem_addr),
    .mem_enable(mem_enable),
    .mem_write(mem_write),
    .bus_commit(bus_commit),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_hit(mem_hit),
`ifdef TIMER_APU_TICK_EN
    .apu_div_tick(apu_div_tick),
`endif
    .irq_timer(irq_timer)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [7:0] exp);
    mem_addr = addr;
    mem_enable = 1'b1;
    mem_write = 1'b0;
    bus_commit = 1'b0;
    #1;
    chk(name, mem_data_out, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data, input logic cm = 1'b1, input logic en = 1'b1);
    mem_addr = addr;
    mem_enable = en;
    mem_write = 1'b1;
    bus_commit = cm;
    mem_data_in = data;
    @(posedge clk);
    @(negedge clk);
    mem_enable = 1'b0;
    mem_write = 1'b0;
    bus_commit = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_enable = 1'b0;
    mem_write = 1'b0;
    bus_commit = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // overflow tick lands on the 17th edge after release; returns just after the 16th
  task automatic start_ovf();
    do_reset();
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFF);
    wr(16'hFF07, 8'h05);
    repeat (13) @(negedge clk);
  endtask

  initial begin
    v[0] = '{1'b1, 1'b1, 1'b1, 16'hFF06, 8'hAB, 1'b1, 8'hAB};
    v[1] = '{1'b1, 1'b1, 1'b1, 16'hFF05, 8'h5A, 1'b1, 8'h5A};
    v[2] = '{1'b1, 1'b1, 1'b1, 16'hFF07, 8'h02, 1'b1, 8'hFA};
    v[3] = '{1'b1, 1'b0, 1'b1, 16'hFF06, 8'h11, 1'b1, 8'hAB};
    v[4] = '{1'b0, 1'b0, 1'b1, 16'hFF08, 8'h00, 1'b0, 8'hFF};
    v[5] = '{1'b0, 1'b0, 1'b1, 16'hFF03, 8'h00, 1'b0, 8'hFF};
    v[6] = '{1'b0, 1'b0, 1'b0, 16'hFF05, 8'h00, 1'b0, 8'hFF};
    v[7] = '{1'b1, 1'b1, 1'b1, 16'hFF04, 8'h77, 1'b1, 8'h00};
    v[8] = '{1'b1, 1'b1, 1'b1, 16'hFF07, 8'hF8, 1'b1, 8'hF8};
    v[9] = '{1'b0, 1'b0, 1'b1, 16'hFF05, 8'h00, 1'b1, 8'h5A};
    reset_n = 1'b0;
    mem_addr = 16'h0000;
    mem_enable = 1'b0;
    mem_write = 1'b0;
    bus_commit = 1'b0;
    mem_data_in = 8'h00;
    @(negedge clk);
    rd_chk("rst_div", 16'hFF04, 8'h00);
    rd_chk("rst_tima", 16'hFF05, 8'h00);
    rd_chk("rst_tma", 16'hFF06, 8'h00);
    rd_chk("rst_tac", 16'hFF07, 8'hF8);
    chk("rst_hit", {7'b0, mem_hit}, 8'h01);
    chk("rst_irq", {7'b0, irq_timer}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (255) @(negedge clk);
    rd_chk("div_255", 16'hFF04, 8'h00);
    @(negedge clk);
    rd_chk("div_256", 16'hFF04, 8'h01);
    repeat (65280) @(negedge clk);
    rd_chk("div_wrap", 16'hFF04, 8'h00);
    rd_chk("tima_idle", 16'hFF05, 8'h00);
`ifdef TIMER_APU_TICK_EN
    chk("apu_ticks", apu_cnt[7:0], 8'd8);
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (v[i].wr) wr(v[i].addr, v[i].wd, v[i].cm, v[i].en);
      mem_addr = v[i].addr;
      mem_enable = v[i].en;
      mem_write = 1'b0;
      bus_commit = 1'b0;
      #1;
      chk($sformatf("vec%0d_hit", i), {7'b0, mem_hit}, {7'b0, v[i].hit});
      chk($sformatf("vec%0d_data", i), mem_data_out, v[i].rd);
      @(negedge clk);
    end
    do_reset();
    wr(16'hFF07, 8'h05);
    repeat (15) @(negedge clk);
    rd_chk("bit3_16", 16'hFF05, 8'h00);
    @(negedge clk);
    rd_chk("bit3_17", 16'hFF05, 8'h01);
    repeat (239) @(negedge clk);
    rd_chk("bit3_256", 16'hFF05, 8'h0F);
    @(negedge clk);
    rd_chk("bit3_257", 16'hFF05, 8'h10);
    start_ovf();
    rd_chk("ovf_pre", 16'hFF05, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_chk("ovf_hold", 16'hFF05, 8'h00);
      chk("ovf_irq_lo", {7'b0, irq_timer}, 8'h00);
    end
    @(negedge clk);
    rd_chk("ovf_reload", 16'hFF05, 8'hAB);
    chk("ovf_irq_pulse", {7'b0, irq_timer}, 8'h01);
    @(negedge clk);
    chk("ovf_irq_end", {7'b0, irq_timer}, 8'h00);
    start_ovf();
    repeat (2) @(negedge clk);
    wr(16'hFF05, 8'h33);
    rd_chk("ovf_wr", 16'hFF05, 8'h33);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= irq_timer;
    end
    chk("ovf_wr_no_irq", {7'b0, seen}, 8'h00);
    rd_chk("ovf_wr_idle", 16'hFF05, 8'h33);
    start_ovf();
    repeat (5) @(negedge clk);
    rd_chk("rl_start", 16'hFF05, 8'hAB);
    wr(16'hFF05, 8'h44);
    rd_chk("rl_tima_wr", 16'hFF05, 8'hAB);
    wr(16'hFF06, 8'h55);
    rd_chk("rl_tma_wr_tima", 16'hFF05, 8'h55);
    rd_chk("rl_tma_wr_tma", 16'hFF06, 8'h55);
    do_reset();
    wr(16'hFF07, 8'h05);
    repeat (7) @(negedge clk);
    wr(16'hFF04, 8'h00);
    rd_chk("divw_div", 16'hFF04, 8'h00);
    rd_chk("divw_pre", 16'hFF05, 8'h00);
    @(negedge clk);
    rd_chk("divw_inc", 16'hFF05, 8'h01);
    repeat (5) @(negedge clk);
    rd_chk("divw_once", 16'hFF05, 8'h01);
    repeat (2) @(negedge clk);
    wr(16'hFF07, 8'h00);
    rd_chk("tacw_pre", 16'hFF05, 8'h01);
    @(negedge clk);
    rd_chk("tacw_inc", 16'hFF05, 8'h02);
    repeat (20) @(negedge clk);
    rd_chk("tacw_once", 16'hFF05, 8'h02);
    start_ovf();
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    rd_chk("mid_rst_tima", 16'hFF05, 8'h00);
    rd_chk("mid_rst_tma", 16'hFF06, 8'h00);
    rd_chk("mid_rst_tac", 16'hFF07, 8'hF8);
    rd_chk("mid_rst_div", 16'hFF04, 8'h00);
    chk("mid_rst_irq", {7'b0, irq_timer}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= irq_timer;
    end
    chk("mid_rst_no_irq", {7'b0, seen}, 8'h00);
    rd_chk("mid_rst_tima_after", 16'hFF05, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_regs.md
Name: timer_regs

Overview:
- Memory-mapped timer peripheral. It is a bus responder on the CPU system bus and implements the DIV, TIMA, TMA and TAC registers at FF04–FF07.
- Holds a free-running 16-bit system counter clocked at 4 MHz.
- Increments TIMA on falling edges of a selected counter bit.
- On TIMA overflow, performs the delayed TMA reload and pulses a timer interrupt request to the interrupt controller.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.

Ports:
- clk  in  1  system clock (4 MHz, same clock as CPU)
- reset_n  in  1  asynchronous reset, active-low
- mem_addr  in  16  bus address from CPU
- mem_enable  in  1  bus access enable
- mem_write  in  1  bus write enable
- bus_commit  in  1  one-clock strobe per M-cycle (CPU T-cycle 3 edge); writes take effect only when high
- mem_data_in  in  8  write data from CPU
- mem_data_out  out  8  read data; combinational
- mem_hit  out  1  mem_enable && address in BASE_ADDR..BASE_ADDR+3
- irq_timer  out  1  one-clock interrupt request pulse

Behaviour:
- Reset (async, reset_n=0): sys_counter=0, TIMA=0, TMA=0, TAC=0, edge_prev=0, state=IDLE, irq_timer=0. mem_hit and mem_data_out follow their inputs combinationally, also during reset.
- sys_counter: +1 every clk, wraps FFFF->0000. DIV reads sys_counter[15:8].
- Register writes occur when mem_enable, mem_write, bus_commit and the address matches.
  - Any write to DIV clears sys_counter to 0; the data value is ignored.
- Reads:
  - DIV = counter[15:8].
  - TIMA and TMA read as stored.
  - TAC reads {5'b11111, TAC[2:0]}.
  - On no hit, mem_data_out = 8'hFF.
- Tick source:
  - sel = sys_counter[b] & TAC[2], where b = 9, 3, 5, 7 for TAC[1:0] = 0, 1, 2, 3.
  - edge_prev <= sel every clk.
  - Increment TIMA when edge_prev=1 and sel=0.
  - Consequence: a DIV write or TAC change that drops sel from 1 to 0 produces one spurious increment. This is required behaviour.
- Overflow FSM, states IDLE, OVF, RELOAD:
  - IDLE: an increment from FF sets TIMA=00 and moves to OVF with a 2-bit count=0.
  - OVF lasts 4 clks; TIMA reads 00.
    - A TIMA write during OVF loads the written value, returns to IDLE, and raises no irq.
    - Ticks during OVF increment TIMA normally from 00.
  - On the 4th OVF clk: TIMA <= TMA, irq_timer=1 for that one clk, go to RELOAD.
  - RELOAD lasts 4 clks.
    - TIMA writes are ignored.
    - A TMA write updates TMA and also TIMA with the same value.
    - Ticks are still applied.
    - Then return to IDLE.
- Simultaneous events:
  - Write to TIMA and a tick in the same clk: the write wins.
  - DIV write plus TIMA overflow in the same clk: both take effect.
  - Reset mid-OVF: everything clears and no irq is produced.
- Latency: register write visible on read in the clk after the commit edge. irq_timer is exactly 4 clks after the overflow tick.

Optional Feature:
- Macro TIMER_APU_TICK_EN.
- When defined: adds output apu_div_tick (1 bit, reset 0). It pulses for one clk on every falling edge of sys_counter[12] (512 Hz frame-sequencer clock), including the edge caused by a DIV write.
- When undefined: the port and its edge register are absent.

Decomposition:
- Package timer_pkg holds:
  - register offset localparams: DIV=0, TIMA=1, TMA=2, TAC=3
  - timer_state_e (TimerIdle, TimerOvf, TimerReload)
  - the TAC-to-bit-index function
- No sub-module. The block is a single module; the counter, edge detector and FSM are too tightly coupled to split usefully.

Test Plan:
- Reset release, TAC=0 -> after 256 clks DIV=01; after 65536 clks DIV=00 (wrap); TIMA stays 00.
- TAC=05 (bit3), TIMA=00 -> TIMA=01 after 16 clks; TIMA=10 after 256 clks.
- TMA=AB, TIMA=FF, TAC=05 -> next tick: TIMA reads 00 for 4 clks, then AB with irq_timer high exactly 1 clk.
- Overflow, then write TIMA=33 during OVF -> TIMA=33, no irq, FSM IDLE. Write TIMA=44 during RELOAD -> ignored, TIMA=TMA. Write TMA=55 during RELOAD -> TIMA=55.
- TAC=05, counter[3]=1 -> DIV write clears counter and TIMA increments once; TAC write 05->00 with bit3=1 -> one increment.
- Reads of FF07 with TAC=02 -> F A; read address FF08 -> mem_hit=0, data FF. Assert reset_n mid-OVF -> all registers 00, irq never pulses.
